// File: rtl/keypad_lock_ctrl_if.sv
// Keypad encoder to lock controller bundle: encoder lines in, lock status out.
interface keypad_lock_ctrl_if;
  logic       b0;
  logic       b1;
  logic       b2;
  logic       b3;
  logic       chk;
  logic       star;
  logic       sharp;
  logic       unlock;
  logic       fail;
  logic       locked_out;
  logic [3:0] digit_cnt;
  logic [2:0] fail_cnt;

  modport master (
    output b0, b1, b2, b3, chk, star, sharp,
    input  unlock, fail, locked_out, digit_cnt, fail_cnt
  );

  modport slave (
    input  b0, b1, b2, b3, chk, star, sharp,
    output unlock, fail, locked_out, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Passcode lock behind the 12-key encoder: sync, press-edge detect, entry FSM, timers.
// Optional macro KEY_DEBOUNCE_EN adds a DB_CYCLES stability filter on the key level.
module keypad_lock_ctrl #(
  parameter int                 DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] CODE       = 16'h1234,
  parameter int                 OPEN_CYCLES = 1000,
  parameter int                 LOCK_CYCLES = 5000,
  parameter int                 MAX_FAIL    = 3,
  parameter int                 DB_CYCLES   = 16
) (
  input logic               clk,
  input logic               rst,
  keypad_lock_ctrl_if.slave kp
);
  localparam int BUF_W = 4 * DIGITS;
  localparam int OT_W  = $clog2(OPEN_CYCLES) + 1;
  localparam int LT_W  = $clog2(LOCK_CYCLES) + 1;

  if (DIGITS < 1 || DIGITS > 8 || MAX_FAIL < 1 || MAX_FAIL > 7 || DB_CYCLES < 1)
  begin : g_bad_param
    $error("keypad_lock_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

  logic [6:0] sync1, sync2;
  logic [1:0] warm;
  logic       lvl, lvl_q;
  logic [3:0] ln_bcd;
  logic       ln_chk, ln_star, ln_sharp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      warm  <= '0;
    end else begin
      sync1 <= {kp.sharp, kp.star, kp.chk, kp.b3, kp.b2, kp.b1, kp.b0};
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES) + 1;
  logic [DB_W-1:0] db_cnt;
  logic            db_lvl;
  logic [6:0]      cap;
  logic            key_any_s;

  assign key_any_s = sync2[4] | sync2[5] | sync2[6];

  // Lines are captured when the filtered level flips, so the class matches the settled press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
      cap    <= '0;
    end else if (key_any_s == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= key_any_s;
      cap    <= sync2;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign lvl      = db_lvl;
  assign ln_bcd   = cap[3:0];
  assign ln_chk   = cap[4];
  assign ln_star  = cap[5];
  assign ln_sharp = cap[6];
`else
  assign lvl      = sync2[4] | sync2[5] | sync2[6];
  assign ln_bcd   = sync2[3:0];
  assign ln_chk   = sync2[4];
  assign ln_star  = sync2[5];
  assign ln_sharp = sync2[6];
`endif

  // Until the synchroniser has filled, the previous level reads as pressed so a held key is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lvl_q <= 1'b1;
    else if (!warm[1]) lvl_q <= 1'b1;
    else              lvl_q <= lvl;
  end

  logic press, ev_digit, ev_star, ev_sharp;
  assign press    = lvl & ~lvl_q;
  assign ev_digit = press &  ln_chk & ~ln_star & ~ln_sharp;
  assign ev_star  = press & ~ln_chk &  ln_star & ~ln_sharp;
  assign ev_sharp = press & ~ln_chk & ~ln_star &  ln_sharp;

  state_t           state;
  logic [BUF_W-1:0] buffer;
  logic             overflow;
  logic [OT_W-1:0]  open_tmr;
  logic [LT_W-1:0]  lock_tmr;
  logic [3:0]       digit_cnt;
  logic [2:0]       fail_cnt;
  logic             unlock, fail, locked_out;

  assign kp.digit_cnt  = digit_cnt;
  assign kp.fail_cnt   = fail_cnt;
  assign kp.unlock     = unlock;
  assign kp.fail       = fail;
  assign kp.locked_out = locked_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      buffer     <= '0;
      overflow   <= 1'b0;
      open_tmr   <= '0;
      lock_tmr   <= '0;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      unlock     <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      fail <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (ev_digit) begin
            state <= ENTRY;
            if (digit_cnt == 4'(DIGITS)) begin
              overflow <= 1'b1;
            end else begin
              buffer    <= (buffer << 4) | BUF_W'(ln_bcd);
              digit_cnt <= digit_cnt + 4'd1;
            end
          end else if (ev_star) begin
            state     <= IDLE;
            buffer    <= '0;
            digit_cnt <= '0;
            overflow  <= 1'b0;
          end else if (ev_sharp && digit_cnt != 4'd0) begin
            buffer    <= '0;
            digit_cnt <= '0;
            overflow  <= 1'b0;
            if (digit_cnt == 4'(DIGITS) && !overflow && buffer == CODE) begin
              state    <= OPEN;
              open_tmr <= OT_W'(OPEN_CYCLES - 1);
              fail_cnt <= '0;
              unlock   <= 1'b1;
            end else begin
              fail     <= 1'b1;
              fail_cnt <= fail_cnt + 3'd1;
              if (fail_cnt + 3'd1 == 3'(MAX_FAIL)) begin
                state      <= LOCKOUT;
                lock_tmr   <= LT_W'(LOCK_CYCLES - 1);
                locked_out <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        OPEN: begin
          if (ev_sharp || open_tmr == '0) begin
            state  <= IDLE;
            unlock <= 1'b0;
          end else begin
            open_tmr <= open_tmr - OT_W'(1);
          end
        end
        LOCKOUT: begin
          if (lock_tmr == '0) begin
            state      <= IDLE;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
          end else begin
            lock_tmr <= lock_tmr - LT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
